// File: rtl/axil_rst_sequencer.sv
// rtl/axil_rst_sequencer.sv - AXI-Lite programmable downstream reset sequencer
// Delay-then-assert reset pulse generator with POR pass-through and status counter.
module axil_rst_sequencer #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 4,
  parameter logic [15:0] DEF_DELAY   = 16'd2,
  parameter logic [15:0] DEF_LEN     = 16'd5,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [3:0]              wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    rst_out_n,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ASSERT} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [15:0]            len_lat_q, len_lat_d;
  logic [15:0]            delay_q, delay_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            seq_cnt_q, seq_cnt_d;
  logic                   force_q, force_d;
  logic                   start_q, start_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rst_out_q, rst_out_d;
  logic                   awready_q, awready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   wr_hs, rd_hs, w_ok, r_ok;
  logic [31:0]            rd_val;
  logic                   unused_bits;

  assign unused_bits = ^{wdata[DATA_WIDTH-1:16], wstrb[3:2], awaddr[1:0], araddr[1:0]};

  assign awready   = awready_q;
  assign wready    = awready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign rst_out_n = rst_out_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_lat_d = len_lat_q;
    delay_d   = delay_q;
    len_d     = len_q;
    seq_cnt_d = seq_cnt_q;
    force_d   = force_q;
    start_d   = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    wr_hs = awready_q && awvalid && wvalid;
    rd_hs = arready_q && arvalid;
    w_ok  = ((awaddr >> 4) == '0);
    r_ok  = ((araddr >> 4) == '0);
    awready_d = awvalid && wvalid && !bvalid_q && !awready_q;
    arready_d = arvalid && !rvalid_q && !arready_q;

    // START is registered for one cycle so the sequence begins the edge after the handshake
    if (wr_hs && w_ok) begin
      case (awaddr[3:2])
        2'd0: if (wstrb[0]) begin
          force_d = wdata[1];
          start_d = wdata[0] && (state_q == S_IDLE) && !start_q;
        end
        2'd1: begin
          if (wstrb[0]) delay_d[7:0]  = wdata[7:0];
          if (wstrb[1]) delay_d[15:8] = wdata[15:8];
        end
        2'd2: begin
          if (wstrb[0]) len_d[7:0]  = wdata[7:0];
          if (wstrb[1]) len_d[15:8] = wdata[15:8];
        end
        default: ;
      endcase
    end

    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = w_ok ? 2'b00 : 2'b10;
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    case (araddr[3:2])
      2'd0:    rd_val = {30'd0, force_q, 1'b0};
      2'd1:    rd_val = {16'd0, delay_q};
      2'd2:    rd_val = {16'd0, len_q};
      default: rd_val = {seq_cnt_q, 14'd0, rst_out_q, busy};
    endcase
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = r_ok ? 2'b00 : 2'b10;
      rdata_d  = r_ok ? rd_val : 32'd0;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: if (start_q) begin
        if (delay_q != 16'd0) begin
          state_d   = S_DELAY;
          cnt_d     = delay_q;
          len_lat_d = len_q;
        end else begin
          state_d = S_ASSERT;
          cnt_d   = (len_q == 16'd0) ? 16'd1 : len_q;
        end
      end
      S_DELAY: if (cnt_q == 16'd1) begin
        state_d = S_ASSERT;
        cnt_d   = (len_lat_q == 16'd0) ? 16'd1 : len_lat_q;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
      S_ASSERT: if (cnt_q == 16'd1) begin
        state_d   = S_IDLE;
        seq_cnt_d = seq_cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Output register is fed from next-state values so it has no extra cycle of lag
    sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
    rst_out_d = !((state_d == S_ASSERT) || force_d || !sync_d[SYNC_STAGES-1]);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      len_lat_q <= 16'd0;
      delay_q   <= DEF_DELAY;
      len_q     <= DEF_LEN;
      seq_cnt_q <= 16'd0;
      force_q   <= 1'b0;
      start_q   <= 1'b0;
      sync_q    <= '0;
      rst_out_q <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_lat_q <= len_lat_d;
      delay_q   <= delay_d;
      len_q     <= len_d;
      seq_cnt_q <= seq_cnt_d;
      force_q   <= force_d;
      start_q   <= start_d;
      sync_q    <= sync_d;
      rst_out_q <= rst_out_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_rst_sequencer.sv
// tb/tb_axil_rst_sequencer.sv - self-checking bench for axil_rst_sequencer
// Expected pulse timing is derived from edge indices counted from the START handshake.
module tb_axil_rst_sequencer;

  logic        clk;
  logic        arst_n;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        rst_out_n, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_delay, m_len, m_cnt;
  logic        m_force;

  axil_rst_sequencer #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .arst_n(arst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rst_out_n(rst_out_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] status_word();
    return {m_cnt, 14'd0, !m_force, 1'b0};
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit got = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk);
      if (awready === 1'b1 && wready === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL write_handshake addr=%h awready=%b required 1", a, awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    resp = bresp;
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_bvalid addr=%h got %b required 1", a, bvalid);
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got = 0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk);
      if (arready === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL read_handshake addr=%h arready=%b required 1", a, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    d = rdata; resp = rresp;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_rvalid addr=%h got %b required 1", a, rvalid);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    #15 arst_n = 1'b0;
    #1;
    checks++;
    if ({rst_out_n, busy, awready, wready, bvalid, arready, rvalid, bresp, rresp} !== 11'd0
        || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs rst_out_n=%b busy=%b bvalid=%b rvalid=%b rdata=%h required all 0",
               rst_out_n, busy, bvalid, rvalid, rdata);
    end
    #44 arst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rst_out_n !== 1'b0) begin
      errors++;
      $display("FAIL por_edge1 rst_out_n=%b required 0", rst_out_n);
    end
    @(posedge clk); #1;
    checks++;
    if (rst_out_n !== 1'b1) begin
      errors++;
      $display("FAIL por_edge2 rst_out_n=%b required 1", rst_out_n);
    end
    m_delay = 16'd2; m_len = 16'd5; m_cnt = 16'd0; m_force = 1'b0;
    axi_read(8'h4, d, r);
    checks++;
    if (d !== 32'd2 || r !== 2'b00) begin
      errors++; $display("FAIL reset_delay got %h/%b required 00000002/00", d, r);
    end
    axi_read(8'h8, d, r);
    checks++;
    if (d !== 32'd5 || r !== 2'b00) begin
      errors++; $display("FAIL reset_len got %h/%b required 00000005/00", d, r);
    end
    axi_read(8'hC, d, r);
    checks++;
    if (d !== 32'h0000_0002) begin
      errors++; $display("FAIL reset_status got %h required 00000002", d);
    end
  endtask

  // Program DELAY/LEN, launch, and compare the pulse edge by edge with the model window.
  task automatic test_sequences();
    logic [1:0]  r;
    logic [31:0] d;
    int dl, ln, lw;
    for (int it = 0; it < 8; it++) begin
      if (it == 0) begin dl = 2; ln = 5; end
      else if (it == 1) begin dl = 0; ln = 0; end
      else begin dl = $urandom_range(0, 6); ln = $urandom_range(0, 6); end
      if (it > 0) begin
        axi_write(8'h4, dl, 4'hF, r);
        axi_write(8'h8, ln, 4'hF, r);
        m_delay = dl[15:0]; m_len = ln[15:0];
      end
      lw = (m_len == 0) ? 1 : int'(m_len);
      axi_write(8'h0, 32'h1, 4'hF, r);
      for (int k = 1; k <= int'(m_delay) + lw + 2; k++) begin
        @(posedge clk); #1;
        checks++;
        if (rst_out_n !== !(k >= int'(m_delay) + 1 && k <= int'(m_delay) + lw)
            || busy !== (k <= int'(m_delay) + lw)) begin
          errors++;
          $display("FAIL seq_timeline d=%0d l=%0d k=%0d rst_out_n=%b busy=%b", m_delay, m_len, k,
                   rst_out_n, busy);
        end
      end
      m_cnt++;
      axi_read(8'hC, d, r);
      checks++;
      if (d !== status_word()) begin
        errors++; $display("FAIL seq_status got %h required %h", d, status_word());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  r1, r2;
    logic [31:0] d;
    int lows = 0;
    axi_write(8'h4, 32'd2, 4'hF, r1);
    axi_write(8'h8, 32'd5, 4'hF, r1);
    m_delay = 16'd2; m_len = 16'd5;
    fork
      begin
        axi_write(8'h0, 32'h1, 4'hF, r1);
        axi_write(8'h0, 32'h1, 4'hF, r2);
      end
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (rst_out_n === 1'b0) lows++;
      end
    join
    checks++;
    if (lows != 5 || r2 !== 2'b00) begin
      errors++; $display("FAIL b2b_pulse low_cycles=%0d resp=%b required 5/00", lows, r2);
    end
    m_cnt++;
    axi_read(8'hC, d, r1);
    checks++;
    if (d !== status_word()) begin
      errors++; $display("FAIL b2b_count got %h required %h", d, status_word());
    end
  endtask

  task automatic test_force();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(8'h0, 32'h2, 4'h1, r);
    m_force = 1'b1;
    checks++;
    if (rst_out_n !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL force_on rst_out_n=%b busy=%b required 0/0", rst_out_n, busy);
    end
    axi_read(8'h0, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL force_ctrl got %h required 00000002", d); end
    axi_read(8'hC, d, r);
    checks++;
    if (d !== status_word()) begin
      errors++; $display("FAIL force_status got %h required %h", d, status_word());
    end
    axi_write(8'h0, 32'h0, 4'h1, r);
    m_force = 1'b0;
    checks++;
    if (rst_out_n !== 1'b1) begin
      errors++; $display("FAIL force_off rst_out_n=%b required 1", rst_out_n);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(8'h4, 32'h1234_ABCD, 4'b0001, r);
    m_delay = {m_delay[15:8], 8'hCD};
    axi_read(8'h4, d, r);
    checks++;
    if (d !== {16'd0, m_delay}) begin
      errors++; $display("FAIL wstrb_b0 got %h required %h", d, {16'd0, m_delay});
    end
    axi_write(8'h4, 32'hFFFF_56FF, 4'b0010, r);
    m_delay = {8'h56, m_delay[7:0]};
    axi_write(8'h8, 32'hFFFF_FFFF, 4'b1100, r);
    axi_read(8'h4, d, r);
    checks++;
    if (d !== {16'd0, m_delay}) begin
      errors++; $display("FAIL wstrb_b1 got %h required %h", d, {16'd0, m_delay});
    end
    axi_read(8'h8, d, r);
    checks++;
    if (d !== {16'd0, m_len}) begin
      errors++; $display("FAIL wstrb_hi got %h required %h", d, {16'd0, m_len});
    end
    axi_write(8'h0, 32'h3, 4'b0000, r);
    axi_write(8'hC, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== 2'b00 || rst_out_n !== 1'b1) begin
      errors++; $display("FAIL wstrb_ro resp=%b rst_out_n=%b required 00/1", r, rst_out_n);
    end
    axi_write(8'h4, 32'd2, 4'hF, r);
    m_delay = 16'd2;
    repeat (12) @(posedge clk);
    #1;
    axi_read(8'hC, d, r);
    checks++;
    if (d !== status_word()) begin
      errors++; $display("FAIL wstrb_nostart got %h required %h", d, status_word());
    end
  endtask

  task automatic test_bad_addr();
    logic [1:0]  r;
    logic [31:0] d;
    bit got = 0;
    bready = 1'b0;
    awaddr = 8'h10; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk);
      if (awready === 1'b1) got = 1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || !got) begin
        errors++;
        $display("FAIL bad_hold cyc=%0d bvalid=%b bresp=%b awready=%b hs=%0d required 1/10/0/1",
                 i, bvalid, bresp, awready, got);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bad_release bvalid=%b required 0", bvalid); end
    axi_read(8'h10, d, r);
    checks++;
    if (d !== 32'd0 || r !== 2'b10) begin
      errors++; $display("FAIL bad_read got %h/%b required 00000000/10", d, r);
    end
    repeat (12) @(posedge clk);
    #1;
    axi_read(8'h0, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL bad_ctrl got %h required 00000000", d); end
    axi_read(8'hC, d, r);
    checks++;
    if (d !== status_word()) begin
      errors++; $display("FAIL bad_status got %h required %h", d, status_word());
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0]  wr, rr;
    logic [31:0] d, pre;
    pre = status_word();
    fork
      axi_write(8'h0, 32'h1, 4'hF, wr);
      axi_read(8'hC, d, rr);
    join
    checks++;
    if (d !== pre || wr !== 2'b00 || rr !== 2'b00) begin
      errors++; $display("FAIL simul_status got %h/%b/%b required %h/00/00", d, wr, rr, pre);
    end
    repeat (30) @(posedge clk);
    #1;
    m_cnt++;
    axi_read(8'hC, d, rr);
    checks++;
    if (d !== status_word()) begin
      errors++; $display("FAIL simul_after got %h required %h", d, status_word());
    end
  endtask

  task automatic test_abort();
    logic [1:0]  r;
    logic [31:0] d;
    axi_write(8'h4, 32'd3, 4'hF, r);
    axi_write(8'h8, 32'd10, 4'hF, r);
    axi_write(8'h0, 32'h1, 4'hF, r);
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (rst_out_n !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre rst_out_n=%b busy=%b required 0/1", rst_out_n, busy);
    end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (rst_out_n !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_now rst_out_n=%b busy=%b required 0/0", rst_out_n, busy);
    end
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rst_out_n !== 1'b0) begin errors++; $display("FAIL abort_edge1 rst_out_n=%b required 0", rst_out_n); end
    @(posedge clk); #1;
    checks++;
    if (rst_out_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_edge2 rst_out_n=%b busy=%b required 1/0", rst_out_n, busy);
    end
    m_delay = 16'd2; m_len = 16'd5; m_cnt = 16'd0; m_force = 1'b0;
    axi_read(8'hC, d, r);
    checks++;
    if (d !== 32'h0000_0002) begin errors++; $display("FAIL abort_status got %h required 00000002", d); end
    axi_read(8'h4, d, r);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL abort_delay got %h required 00000002", d); end
  endtask

  initial begin
    arst_n = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    test_reset();
    test_sequences();
    test_back_to_back();
    test_force();
    test_wstrb();
    test_bad_addr();
    test_simultaneous();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
